// File: rtl/arb_pkg.sv
// Shared types, sizes and the request-rotation helper for the round-robin arbiter.
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {S_IDLE, S_GRANT} arb_state_t;

  // rot[k] = req[(ptr+k) mod n]; bits at or above n are zero so smaller arbiters reuse it.
  function automatic logic [ARB_N-1:0] rot_req(input logic [ARB_N-1:0]     req,
                                               input logic [ARB_IDX_W-1:0] ptr,
                                               input int                   n);
    logic [ARB_N-1:0]     rot;
    logic [ARB_IDX_W-1:0] src;
    rot = '0;
    for (int k = 0; k < ARB_N; k++) begin
      if (k < n) begin
        src    = ARB_IDX_W'((int'(ptr) + k) % n);
        rot[k] = req[src];
      end
    end
    return rot;
  endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational priority encoder: the highest set input bit wins.
module prio_enc_n #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     in,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) idx = IDX_W'(i);
    end
  end

  assign any = |in;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, hold-until-release and an
// optional hold-time limit that revokes a grant after MAX_HOLD cycles.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             timeout_q, timeout_d;

  logic [ARB_N-1:0] rot_full;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] enc_idx;
  logic             req_any;
  logic [IDX_W-1:0] winner;
  logic             rel_other;
  logic             rel_limit;

  assign rot_full = rot_req(ARB_N'(req), ARB_IDX_W'(ptr_q), N);
  assign rot      = rot_full[N-1:0];

  prio_enc_n #(.N(N), .IDX_W(IDX_W)) u_enc (
    .in  (rot),
    .idx (enc_idx),
    .any (req_any)
  );

  // N is a power of two, so IDX_W-bit addition is already mod N.
  assign winner    = ptr_q + enc_idx;
  assign rel_other = done | ~req[gnt_idx_q] | ~en;
  assign rel_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && req_any) begin
          state_d    = S_GRANT;
          gnt_d      = N'(1) << winner;
          gnt_idx_d  = winner;
          gnt_vld_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
        end
      end
      S_GRANT: begin
        if (rel_other || rel_limit) begin
          state_d   = S_IDLE;
          gnt_d     = '0;
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_idx_q;
          timeout_d = rel_limit && !rel_other;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic, all compared
// every cycle against a transaction-level model of the arbitration rules.
module tb_rr_arbiter8;

  localparam int N        = 8;
  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter8 #(.N(N), .IDX_W(3), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: who holds the resource, for how long, and who held it last.
  int  m_holder = -1;
  int  m_len    = 0;
  int  m_ptr    = 0;
  int  m_idx    = 0;
  bit  m_to     = 1'b0;
  bit  m_other;

  // Walk downward from the last holder, wrapping; the last holder itself comes last.
  function automatic int pick(input logic [7:0] r, input int p);
    for (int j = 1; j <= N; j++) begin
      int c;
      c = (p - j + N) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_holder = -1; m_len = 0; m_ptr = 0; m_idx = 0; m_to = 1'b0;
    end else if (m_holder < 0) begin
      m_to = 1'b0;
      if (en && req != 8'h00) begin
        m_holder = pick(req, m_ptr);
        m_idx    = m_holder;
        m_len    = 1;
      end
    end else begin
      m_other = done || !req[m_holder] || !en;
      if (m_other || (MAX_HOLD != 0 && m_len == MAX_HOLD)) begin
        m_to     = !m_other;
        m_ptr    = m_holder;
        m_holder = -1;
      end else begin
        m_len++;
        m_to = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      check("gnt",     gnt,     (m_holder >= 0) ? (32'h1 << m_holder) : 32'h0);
      check("gnt_vld", gnt_vld, (m_holder >= 0) ? 32'h1 : 32'h0);
      check("gnt_idx", gnt_idx, m_idx[2:0]);
      check("timeout", timeout, m_to);
      check("onehot0", $onehot0(gnt), 1);
      check("vld_vs_gnt", gnt_vld, |gnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset(input logic [7:0] r);
    #2;
    rst_n = 1'b0;
    en    = 1'b1;
    done  = 1'b0;
    req   = r;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  int seq[$];
  int at[$];
  int cnt;
  int t2_exp[4] = '{7, 0, 7, 0};
  int t3_exp[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

  initial begin
    rst_n = 1'b1; en = 1'b1; req = 8'hFF; done = 1'b0;
    #1 rst_n = 1'b0;

    // Reset holds everything at zero even with all requests up; first grant goes to 7.
    cyc(); cyc();
    check("t1_rst_gnt", gnt, 0);
    check("t1_rst_vld", gnt_vld, 0);
    check("t1_rst_idx", gnt_idx, 0);
    check("t1_rst_to",  timeout, 0);
    rst_n = 1'b1;
    cyc();
    check("t1_gnt", gnt, 8'h80);
    check("t1_idx", gnt_idx, 7);

    // Two requesters alternate with a bubble between grants.
    do_reset(8'h81);
    seq.delete(); at.delete();
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (gnt_vld) begin seq.push_back(int'(gnt_idx)); at.push_back(c); end
      done = gnt_vld;
    end
    done = 1'b0;
    check("t2_count", seq.size() >= 4, 1);
    for (int i = 0; i < 4; i++) check("t2_idx", (i < seq.size()) ? seq[i] : 99, t2_exp[i]);
    for (int i = 0; i < 3; i++) check("t2_gap", (i + 1 < at.size()) ? at[i+1] - at[i] : 99, 2);

    // Full rotation with everyone requesting and done every grant cycle.
    do_reset(8'hFF);
    done = 1'b1;
    seq.delete();
    for (int c = 0; c < 18; c++) begin
      cyc();
      if (gnt_vld) seq.push_back(int'(gnt_idx));
    end
    done = 1'b0;
    check("t3_count", seq.size(), 9);
    for (int i = 0; i < 9; i++) check("t3_idx", (i < seq.size()) ? seq[i] : 99, t3_exp[i]);

    // Hold limit: a lone requester is cut off after exactly MAX_HOLD cycles.
    do_reset(8'h04);
    cyc();
    cnt = 0;
    while (gnt_vld && cnt < 40) begin cnt++; cyc(); end
    check("t4_hold_len", cnt, 16);
    check("t4_timeout",  timeout, 1);
    check("t4_bubble",   gnt_vld, 0);
    cyc();
    check("t4_regrant_idx", gnt_idx, 2);
    check("t4_regrant_vld", gnt_vld, 1);
    check("t4_to_clear",    timeout, 0);

    // done on the last allowed cycle: released, but not counted as a timeout.
    do_reset(8'h04);
    cyc();
    repeat (15) cyc();
    done = 1'b1;
    cyc();
    check("t5_rel_vld", gnt_vld, 0);
    check("t5_rel_to",  timeout, 0);
    done = 1'b0;

    // Enable drop revokes the grant and blocks new ones.
    do_reset(8'hFF);
    cyc(); cyc();
    en = 1'b0;
    cyc();
    check("t5_en_drop", gnt_vld, 0);
    repeat (4) begin cyc(); check("t5_en_hold", gnt_vld, 0); end
    en = 1'b1;

    // Asynchronous reset in the middle of a grant to requester 3.
    do_reset(8'hFF);
    done = 1'b1;
    cnt = 0;
    while (!(gnt_vld && gnt_idx == 3'd3) && cnt < 40) begin cyc(); cnt++; end
    check("t6_reach3", gnt_vld && gnt_idx == 3'd3, 1);
    done = 1'b0;
    cyc();
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_gnt", gnt, 0);
    check("t6_async_vld", gnt_vld, 0);
    check("t6_async_idx", gnt_idx, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t6_first_idx", gnt_idx, 7);
    check("t6_first_gnt", gnt, 8'h80);

    // Random traffic: sticky requests, occasional done/enable drops and resets.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if ($urandom_range(7) == 0)
        req = ($urandom_range(1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      done = ($urandom_range(15) == 0);
      en   = ($urandom_range(31) != 0);
      if ($urandom_range(499) == 0) do_reset(8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
